// File: rtl/clock_gen.sv
// Programmable square-wave generator. Divides the system clock by an even
// ratio (2 * half-period), producing a registered level output, one-cycle
// rise/fall strobes coincident with the new level, and a count of completed
// rising transitions. The half-period is re-sampled only at reset and on each
// toggle, so a half that is already under way is never shortened or stretched.
module clock_gen #(
    parameter int   HALF_PERIOD = 12,
    parameter int   DIV_W       = 8,
    parameter int   CNT_W       = 16,
    parameter logic INIT_LEVEL  = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [DIV_W-1:0] half_period,
    output logic             clk_out,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [DIV_W-1:0] DIV_ZERO   = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
    localparam logic [DIV_W-1:0] DEFAULT_HP = DIV_W'(HALF_PERIOD);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // A zero request selects the built-in default half-period.
    function automatic logic [DIV_W-1:0] eff_half_period(input logic [DIV_W-1:0] hp_in);
        logic [DIV_W-1:0] hp_out;
        if (hp_in == DIV_ZERO) begin
            hp_out = DEFAULT_HP;
        end else begin
            hp_out = hp_in;
        end
        return hp_out;
    endfunction

    logic [DIV_W-1:0] phase_q,  phase_d;
    logic [DIV_W-1:0] active_q, active_d;
    logic             level_q,  level_d;
    logic             rise_q,   rise_d;
    logic             fall_q,   fall_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic [DIV_W-1:0] hp_s;
    logic             terminal_s;

    assign hp_s       = eff_half_period(half_period);
    // active_q is never zero because the effective half-period is at least 1.
    assign terminal_s = (phase_q == (active_q - DIV_ONE));

    // Next-state: advance the phase, toggle at the end of each half, raise strobes.
    always_comb begin
        phase_d  = phase_q;
        active_d = active_q;
        level_d  = level_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        count_d  = count_q;
        if (enable) begin
            if (terminal_s) begin
                phase_d  = DIV_ZERO;
                level_d  = ~level_q;
                active_d = hp_s;
                if (!level_q) begin
                    rise_d  = 1'b1;
                    count_d = count_q + CNT_ONE;
                end else begin
                    fall_d  = 1'b1;
                end
            end else begin
                phase_d = phase_q + DIV_ONE;
            end
        end else begin
            // Frozen: phase, level and count hold; strobes stay low.
            phase_d = phase_q;
        end
    end

    // State register with synchronous reset; reset wins over enable and issues no strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q  <= DIV_ZERO;
            active_q <= hp_s;
            level_q  <= INIT_LEVEL;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            count_q  <= CNT_ZERO;
        end else begin
            phase_q  <= phase_d;
            active_q <= active_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            count_q  <= count_d;
        end
    end

    assign clk_out     = level_q;
    assign rise        = rise_q;
    assign fall        = fall_q;
    assign cycle_count = count_q;

endmodule

// File: tb/tb_clock_gen.sv
// Directed bench for clock_gen: default ratio, runtime ratio with a mid-half
// change, half-period of one, enable gating, mid-run reset and counter wrap.
module tb_clock_gen;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  half_period;
    logic        clk_out, rise, fall;
    logic [15:0] cycle_count;
    logic        clk_out_w, rise_w, fall_w;
    logic [1:0]  cycle_count_w;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    clock_gen dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .half_period (half_period),
        .clk_out     (clk_out),
        .rise        (rise),
        .fall        (fall),
        .cycle_count (cycle_count)
    );

    clock_gen #(.CNT_W(2)) dut_w (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .half_period (half_period),
        .clk_out     (clk_out_w),
        .rise        (rise_w),
        .fall        (fall_w),
        .cycle_count (cycle_count_w)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic [7:0] hp);
        reset       = 1'b1;
        half_period = hp;
        step();
        reset       = 1'b0;
    endtask

    // Expected outputs after enabled edge c with a constant half-period hp, INIT_LEVEL = 1.
    task automatic check_const(input string tag, input int c, input int hp);
        int t;
        t = c / hp;
        check_eq($sformatf("%s c%0d clk", tag, c),  32'(clk_out), (t % 2 == 0) ? 32'd1 : 32'd0);
        check_eq($sformatf("%s c%0d rise", tag, c), 32'(rise),    (c % (2 * hp) == 0) ? 32'd1 : 32'd0);
        check_eq($sformatf("%s c%0d fall", tag, c), 32'(fall),
                 ((c % hp == 0) && (c % (2 * hp) != 0)) ? 32'd1 : 32'd0);
        check_eq($sformatf("%s c%0d cnt", tag, c),  32'(cycle_count), 32'(c / (2 * hp)));
    endtask

    initial begin
        logic [20:1] s2_clk;
        s2_clk = 20'b11111_00000_11111_00011;

        reset       = 1'b1;
        enable      = 1'b1;
        half_period = 8'd0;
        step();
        check_eq("rst clk",  32'(clk_out),     32'd1);
        check_eq("rst rise", 32'(rise),        32'd0);
        check_eq("rst fall", 32'(fall),        32'd0);
        check_eq("rst cnt",  32'(cycle_count), 32'd0);
        check_eq("rst cnt_w", 32'(cycle_count_w), 32'd0);
        reset = 1'b0;

        // Default ratio, with the 2-bit counter instance running alongside.
        for (int c = 1; c <= 480; c++) begin
            step();
            check_const("s1", c, 12);
            check_eq($sformatf("s1w c%0d cnt", c),  32'(cycle_count_w), 32'((c / 24) % 4));
            check_eq($sformatf("s1w c%0d rise", c), 32'(rise_w), (c % 24 == 0) ? 32'd1 : 32'd0);
            if (c == 96) begin
                check_eq("wrap cnt",  32'(cycle_count_w), 32'd0);
                check_eq("wrap rise", 32'(rise_w),        32'd1);
            end
        end
        check_eq("s1 cnt480", 32'(cycle_count), 32'd20);

        // Runtime ratio 3, changed to 5 while the second half is under way.
        do_reset(8'd3);
        for (int c = 1; c <= 20; c++) begin
            step();
            if (c == 3) half_period = 8'd5;
            check_eq($sformatf("s2 c%0d clk", c),  32'(clk_out), 32'(s2_clk[c]));
            check_eq($sformatf("s2 c%0d rise", c), 32'(rise), (c == 6 || c == 16) ? 32'd1 : 32'd0);
            check_eq($sformatf("s2 c%0d fall", c), 32'(fall), (c == 3 || c == 11) ? 32'd1 : 32'd0);
            check_eq($sformatf("s2 c%0d cnt", c),  32'(cycle_count),
                     (c < 6) ? 32'd0 : ((c < 16) ? 32'd1 : 32'd2));
        end

        // Half-period of one: toggle every cycle.
        do_reset(8'd1);
        for (int c = 1; c <= 8; c++) begin
            step();
            check_const("s3", c, 1);
        end

        // Enable dropped for edges 5..11.
        do_reset(8'd0);
        for (int c = 1; c <= 31; c++) begin
            step();
            if (c == 4)  enable = 1'b0;
            if (c == 11) enable = 1'b1;
            check_eq($sformatf("s4 c%0d clk", c),  32'(clk_out), (c < 19 || c == 31) ? 32'd1 : 32'd0);
            check_eq($sformatf("s4 c%0d fall", c), 32'(fall),    (c == 19) ? 32'd1 : 32'd0);
            check_eq($sformatf("s4 c%0d rise", c), 32'(rise),    (c == 31) ? 32'd1 : 32'd0);
            check_eq($sformatf("s4 c%0d cnt", c),  32'(cycle_count), (c == 31) ? 32'd1 : 32'd0);
        end

        // Reset asserted on edge 30 while high with the phase mid-half.
        do_reset(8'd0);
        for (int c = 1; c <= 29; c++) begin
            step();
        end
        check_eq("s5 pre cnt", 32'(cycle_count), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("s5 rst clk",  32'(clk_out),     32'd1);
        check_eq("s5 rst rise", 32'(rise),        32'd0);
        check_eq("s5 rst fall", 32'(fall),        32'd0);
        check_eq("s5 rst cnt",  32'(cycle_count), 32'd0);
        for (int c = 1; c <= 24; c++) begin
            step();
            check_const("s5", c, 12);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
